uart_sync_fifo: RTL and testbench

- Parametrised synchronous FIFO; next-generation buffer between the UART byte engines (rx deserializer → host, host → tx serializer).
- Supports any depth ≥2, including non-power-of-two, with explicit pointer wrap.
- Adds an occupancy count, programmable almost-full/almost-empty levels, a selectable first-word-fall-through (FWFT) or registered-read mode, synchronous flush, and sticky overflow/underflow flags.

---
 rtl/uart_fifo_pkg.sv | 16 +
 rtl/uart_sync_fifo_if.sv | 37 +++
 rtl/uart_fifo_ptr.sv | 23 ++
 rtl/uart_sync_fifo.sv | 114 +++++++++++
 tb/tb_uart_sync_fifo.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared helpers for the UART byte FIFO: pointer/count width function and
// read-mode selectors.
package uart_fifo_pkg;

    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Bits needed to index n distinct values; never less than 1.
    function automatic int clog2_depth(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/uart_sync_fifo_if.sv
// Handshake, status and control bundle between a UART byte engine and the FIFO.
interface uart_sync_fifo_if
    import uart_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int CW = clog2_depth(DEPTH + 1);

    logic                  flush;
    logic                  clr_err;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, clr_err, wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, count, full, empty,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  flush, clr_err, wr_en, wr_data, rd_en,
        output rd_data, rd_valid, count, full, empty,
               almost_full, almost_empty, overflow, underflow
    );

endinterface

// File: rtl/uart_fifo_ptr.sv
// Wrapping FIFO pointer for arbitrary depth; wraps DEPTH-1 -> 0 by compare.
module uart_fifo_ptr
    import uart_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int PW   = clog2_depth(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO between UART engines and host, with occupancy,
// watermark flags, FWFT or registered read, flush and sticky error flags.
module uart_sync_fifo
    import uart_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = FIFO_MODE_REG,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input logic             clk,
    input logic             reset,
    uart_sync_fifo_if.slave bus
);
    localparam int PW = clog2_depth(DEPTH);
    localparam int CW = clog2_depth(DEPTH + 1);

    if (DEPTH < 2 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_param_err
        $error("uart_sync_fifo: need DEPTH>=2 and AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  empty;
    logic                  full;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  overflow_q;
    logic                  underflow_q;

    // Accept decisions use only registered state; flush masks both sides.
    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign rd_acc = bus.rd_en & ~empty & ~bus.flush;
    assign wr_acc = bus.wr_en & (~full | rd_acc) & ~bus.flush;

    uart_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.flush),
        .inc   (wr_acc),
        .ptr   (wr_ptr)
    );

    uart_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.flush),
        .inc   (rd_acc),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            count_q <= '0;
        end else if (wr_acc && !rd_acc) begin
            count_q <= count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_q <= count_q - 1'b1;
        end
    end

    // A fresh error in the same cycle as clr_err wins over the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (!bus.flush) begin
            overflow_q  <= (overflow_q  & ~bus.clr_err) | (bus.wr_en & ~wr_acc);
            underflow_q <= (underflow_q & ~bus.clr_err) | (bus.rd_en & ~rd_acc);
        end
    end

    assign bus.count        = count_q;
    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign bus.rd_data  = mem[rd_ptr];
        assign bus.rd_valid = ~empty;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] rd_data_q;
        logic                  rd_valid_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) begin
                    rd_data_q <= mem[rd_ptr];
                end
            end
        end

        assign bus.rd_data  = rd_data_q;
        assign bus.rd_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Directed bench for uart_sync_fifo: DEPTH=7 registered-read instance and
// DEPTH=7 first-word-fall-through instance.
module tb_uart_sync_fifo;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    uart_sync_fifo_if #(.DATA_WIDTH(8), .DEPTH(7)) bus_a ();
    uart_sync_fifo_if #(.DATA_WIDTH(8), .DEPTH(7)) bus_b ();

    uart_sync_fifo #(.DATA_WIDTH(8), .DEPTH(7), .FWFT(0)) u_reg (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    uart_sync_fifo #(.DATA_WIDTH(8), .DEPTH(7), .FWFT(1)) u_fwft (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        bus_a.flush = 0; bus_a.clr_err = 0; bus_a.wr_en = 0; bus_a.rd_en = 0; bus_a.wr_data = 0;
    endtask

    logic [7:0] q[$];
    logic [7:0] exp_d;
    logic       do_wr;
    logic       do_rd;

    initial begin
        idle_a();
        bus_b.flush = 0; bus_b.clr_err = 0; bus_b.wr_en = 0; bus_b.rd_en = 0; bus_b.wr_data = 0;
        reset = 1;
        step(); step();
        reset = 0;

        // Reset state
        chk("rst_empty", bus_a.empty, 1);
        chk("rst_full", bus_a.full, 0);
        chk("rst_ae", bus_a.almost_empty, 1);
        chk("rst_af", bus_a.almost_full, 0);
        chk("rst_count", bus_a.count, 0);
        chk("rst_rdv", bus_a.rd_valid, 0);
        chk("rst_rdd", bus_a.rd_data, 0);
        chk("rst_ovf", bus_a.overflow, 0);

        // Fill to full, then one rejected write
        for (int i = 0; i < 7; i++) begin
            bus_a.wr_en = 1; bus_a.wr_data = 8'(8'h11 * (i + 1));
            step();
            chk("fill_count", bus_a.count, i + 1);
            chk("fill_af", bus_a.almost_full, (i + 1) >= 5);
            chk("fill_ae", bus_a.almost_empty, (i + 1) <= 2);
        end
        chk("full", bus_a.full, 1);
        bus_a.wr_data = 8'h88;
        step();
        chk("ovf_set", bus_a.overflow, 1);
        chk("ovf_count", bus_a.count, 7);
        bus_a.wr_en = 0;

        // Drain in order
        for (int i = 0; i < 7; i++) begin
            bus_a.rd_en = 1;
            step();
            chk("pop_data", bus_a.rd_data, 8'(8'h11 * (i + 1)));
            chk("pop_vld", bus_a.rd_valid, 1);
        end
        bus_a.rd_en = 0;
        step();
        chk("drain_vld", bus_a.rd_valid, 0);
        chk("drain_empty", bus_a.empty, 1);
        chk("drain_unf", bus_a.underflow, 0);
        bus_a.rd_en = 1;
        step();
        chk("unf_set", bus_a.underflow, 1);
        chk("unf_vld", bus_a.rd_valid, 0);
        chk("unf_hold", bus_a.rd_data, 8'h77);
        bus_a.rd_en = 0; bus_a.clr_err = 1;
        step();
        chk("clr_ovf", bus_a.overflow, 0);
        chk("clr_unf", bus_a.underflow, 0);
        bus_a.clr_err = 0;

        // Streaming across pointer wrap: offset pointers by 4, then 20 words
        for (int i = 0; i < 30; i++) begin
            do_wr = (i < 4) || (i >= 8 && i < 28);
            do_rd = (i >= 4 && i < 8) || (i >= 10);
            bus_a.wr_en = do_wr; bus_a.rd_en = do_rd; bus_a.wr_data = 8'(8'h30 + i);
            if (do_rd) exp_d = q.pop_front();
            if (do_wr) q.push_back(8'(8'h30 + i));
            step();
            if (do_rd) begin
                chk("strm_data", bus_a.rd_data, exp_d);
                chk("strm_vld", bus_a.rd_valid, 1);
            end
        end
        idle_a();
        step();
        chk("strm_empty", bus_a.empty, 1);
        chk("strm_ovf", bus_a.overflow, 0);
        chk("strm_unf", bus_a.underflow, 0);

        // Full with simultaneous write and read
        for (int i = 0; i < 7; i++) begin
            bus_a.wr_en = 1; bus_a.wr_data = 8'(8'h41 + i);
            step();
        end
        bus_a.rd_en = 1; bus_a.wr_data = 8'h99;
        step();
        chk("fwr_count", bus_a.count, 7);
        chk("fwr_full", bus_a.full, 1);
        chk("fwr_ovf", bus_a.overflow, 0);
        chk("fwr_data", bus_a.rd_data, 8'h41);
        bus_a.wr_en = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("fwr_pop", bus_a.rd_data, (i < 6) ? 8'(8'h42 + i) : 8'h99);
        end
        bus_a.wr_en = 1; bus_a.rd_en = 1; bus_a.wr_data = 8'h5A;
        step();
        chk("ewr_count", bus_a.count, 1);
        chk("ewr_unf", bus_a.underflow, 1);
        chk("ewr_vld", bus_a.rd_valid, 0);
        bus_a.rd_en = 0;

        // Flush with count=4 and a concurrent write
        for (int i = 0; i < 3; i++) begin
            bus_a.wr_data = 8'(8'h61 + i);
            step();
        end
        chk("pre_flush_cnt", bus_a.count, 4);
        bus_a.flush = 1; bus_a.wr_data = 8'hEE;
        step();
        chk("fl_count", bus_a.count, 0);
        chk("fl_empty", bus_a.empty, 1);
        chk("fl_unf", bus_a.underflow, 1);
        chk("fl_ovf", bus_a.overflow, 0);
        chk("fl_rdd", bus_a.rd_data, 8'h99);
        bus_a.flush = 0; bus_a.wr_data = 8'h77;
        step();
        bus_a.wr_en = 0; bus_a.rd_en = 1;
        step();
        chk("postfl_data", bus_a.rd_data, 8'h77);
        chk("postfl_vld", bus_a.rd_valid, 1);
        bus_a.rd_en = 0;

        // Reset while traffic is held
        bus_a.wr_en = 1; bus_a.wr_data = 8'h21;
        step();
        bus_a.rd_en = 1; bus_a.wr_data = 8'hFF;
        reset = 1;
        step();
        reset = 0;
        idle_a();
        chk("mrst_count", bus_a.count, 0);
        chk("mrst_empty", bus_a.empty, 1);
        chk("mrst_full", bus_a.full, 0);
        chk("mrst_ae", bus_a.almost_empty, 1);
        chk("mrst_af", bus_a.almost_full, 0);
        chk("mrst_rdd", bus_a.rd_data, 0);
        chk("mrst_rdv", bus_a.rd_valid, 0);
        chk("mrst_unf", bus_a.underflow, 0);

        // clr_err against a same-cycle error, then alone
        bus_a.rd_en = 1;
        step();
        chk("ce_set", bus_a.underflow, 1);
        bus_a.clr_err = 1;
        step();
        chk("ce_collide", bus_a.underflow, 1);
        bus_a.rd_en = 0;
        step();
        chk("ce_clear", bus_a.underflow, 0);
        idle_a();

        // FWFT instance
        chk("fw_rst_empty", bus_b.empty, 1);
        chk("fw_rst_vld", bus_b.rd_valid, 0);
        bus_b.wr_en = 1; bus_b.wr_data = 8'hA5;
        step();
        bus_b.wr_en = 0;
        chk("fw_data", bus_b.rd_data, 8'hA5);
        chk("fw_empty", bus_b.empty, 0);
        chk("fw_vld", bus_b.rd_valid, 1);
        bus_b.rd_en = 1;
        step();
        bus_b.rd_en = 0;
        chk("fw_pop_empty", bus_b.empty, 1);
        chk("fw_pop_vld", bus_b.rd_valid, 0);
        bus_b.wr_en = 1; bus_b.wr_data = 8'h01;
        step();
        bus_b.wr_data = 8'h02;
        step();
        bus_b.wr_en = 0;
        chk("fw_head1", bus_b.rd_data, 8'h01);
        bus_b.rd_en = 1;
        step();
        bus_b.rd_en = 0;
        chk("fw_head2", bus_b.rd_data, 8'h02);
        chk("fw_count", bus_b.count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
